hw_mod: RTL and testbench
=========================

HW_MOD -- requirements
Module: hw_mod

Interface
REQ-001 Parameter LONG_CYC, default 16: number of cycles the highway stays GREEN before it may yield; legal range 2..255.
REQ-002 Parameter SHORT_CYC, default 4: number of cycles the highway stays YELLOW; legal range 2..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 invk_hw  input  1  level from the farm-way controller handing right-of-way back to the highway.
REQ-006 car_on_fw  input  1  farm-way car sensor, high while a car waits.
REQ-007 invk_fw  output  1  Mealy pulse to the farm-way controller granting it right-of-way.
REQ-008 light_hw  output  2  current highway light (RED=0, YELLOW=1, GREEN=2).
REQ-009 timer_hw_reset  output  1  high in any cycle where the internal cycle timer is cleared.

Function
REQ-010 The block SHALL implement three states (GREEN, YELLOW, RED), with light_hw equal to the state code.
REQ-011 An 8-bit internal counter cnt SHALL increment every cycle and SHALL clear to 0 at the next edge whenever timer_hw_reset is high.
REQ-012 In GREEN, cnt SHALL saturate at LONG_CYC-1.
REQ-013 long_timeout SHALL be (state==GREEN && cnt==LONG_CYC-1).
REQ-014 short_timeout SHALL be (state==YELLOW && cnt==SHORT_CYC-1).
REQ-015 GREEN -> YELLOW SHALL occur at the edge where long_timeout && car_on_fw; otherwise the block SHALL stay GREEN indefinitely.
REQ-016 YELLOW -> RED SHALL occur at the edge where short_timeout is high; car_on_fw changes during YELLOW SHALL be ignored.
REQ-017 RED -> GREEN SHALL occur at the edge where invk_hw is high; the block SHALL otherwise hold RED with no timeout.
REQ-018 invk_hw SHALL be ignored in GREEN and YELLOW.
REQ-019 invk_fw SHALL equal (short_timeout && ~reset), combinationally: exactly one cycle, the last YELLOW cycle.
REQ-020 timer_hw_reset SHALL be high on every transition cycle (GREEN->YELLOW, YELLOW->RED, RED->GREEN) and during reset.
REQ-021 When car_on_fw and long_timeout are high in the same cycle, the transition SHALL occur at that edge, with no extra cycle.
REQ-022 When a car arrives after cnt has saturated, the block SHALL enter YELLOW at the next edge.
REQ-023 An illegal state code SHALL return to GREEN at the next edge.

Reset
REQ-024 While reset is high at an edge: state SHALL become GREEN and cnt SHALL become 0.
REQ-025 After that edge, light_hw SHALL be 2 and invk_fw SHALL be 0.
REQ-026 Reset SHALL take priority over every transition, including reset asserted mid-YELLOW or mid-RED.
REQ-027 The initial (power-up) state SHALL equal the reset state.

Structure
REQ-028 The light encodings RED/YELLOW/GREEN SHALL live in a shared constants package/include used by hw_mod and the farm-way controller.
REQ-029 The cycle counter SHALL be a sub-module tl_timer (8-bit, synchronous clear, saturate at a limit input, exposes count).
REQ-030 hw_mod SHALL contain only the state register, the timeout compares and the Mealy output logic.

Verification (LONG_CYC=16, SHORT_CYC=4; cycle 0 = first cycle after reset deasserts)
REQ-031 No car for 50 cycles -> light_hw=2 throughout; invk_fw never high.
REQ-032 car_on_fw=1 from cycle 0 -> GREEN cycles 0-15, YELLOW 16-19, invk_fw high only in cycle 19, RED from cycle 20.
REQ-033 Car arrives at cycle 30 -> YELLOW at cycle 31; invk_fw only in cycle 34.
REQ-034 In RED, invk_hw high at RED cycle 10 -> GREEN next cycle, cnt=0; a persisting car yields again only after 16 GREEN cycles.
REQ-035 invk_hw held high during GREEN and YELLOW -> no state change caused by it.
REQ-036 reset asserted in the 3rd YELLOW cycle -> GREEN next cycle, cnt=0, invk_fw never pulses.

Source files
------------

// File: rtl/hw_mod_pkg.sv
// Shared light encodings for the highway and farm-way controllers.
package hw_mod_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/hw_mod_timer.sv
// tl_timer: 8-bit free-running cycle counter with synchronous clear and optional saturation.
module tl_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         sat_en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q = '0;

    // Outside saturation the counter wraps, which is harmless because RED has no timeout.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (sat_en && (count_q >= limit)) begin
            count_q <= limit;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hw_mod.sv
// Highway light controller: GREEN until a farm-way car waits past the long timer,
// YELLOW for the short timer, then RED until the farm-way hands right-of-way back.
module hw_mod
    import hw_mod_pkg::*;
#(
    parameter int LONG_CYC  = 16,
    parameter int SHORT_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       invk_hw,
    input  logic       car_on_fw,
    output logic       invk_fw,
    output logic [1:0] light_hw,
    output logic       timer_hw_reset
);

    localparam logic [TIMER_W-1:0] LONG_LIM  = TIMER_W'(LONG_CYC - 1);
    localparam logic [TIMER_W-1:0] SHORT_LIM = TIMER_W'(SHORT_CYC - 1);

    logic [1:0]         state = LIGHT_GREEN;
    logic [1:0]         next_state;
    logic [TIMER_W-1:0] cnt;
    logic               long_timeout;
    logic               short_timeout;
    logic               transition;

    tl_timer #(.W(TIMER_W)) u_timer (
        .clk    (clk),
        .clear  (timer_hw_reset),
        .sat_en (state == LIGHT_GREEN),
        .limit  (LONG_LIM),
        .count  (cnt)
    );

    assign long_timeout  = (state == LIGHT_GREEN)  && (cnt == LONG_LIM);
    assign short_timeout = (state == LIGHT_YELLOW) && (cnt == SHORT_LIM);

    always_comb begin
        next_state = state;
        transition = 1'b0;
        case (state)
            LIGHT_GREEN: begin
                if (long_timeout && car_on_fw) begin
                    next_state = LIGHT_YELLOW;
                    transition = 1'b1;
                end
            end
            LIGHT_YELLOW: begin
                if (short_timeout) begin
                    next_state = LIGHT_RED;
                    transition = 1'b1;
                end
            end
            LIGHT_RED: begin
                if (invk_hw) begin
                    next_state = LIGHT_GREEN;
                    transition = 1'b1;
                end
            end
            default: begin
                next_state = LIGHT_GREEN;
                transition = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LIGHT_GREEN;
        end else begin
            state <= next_state;
        end
    end

    // Right-of-way handshake: invk_fw is a one-cycle grant in the last YELLOW cycle;
    // invk_hw is a level from the farm-way side, honoured only while RED.
    assign invk_fw        = short_timeout && !reset;
    assign timer_hw_reset = reset || transition;
    assign light_hw       = state;

endmodule

// File: tb/tb_hw_mod.sv
// Directed scoreboard bench for hw_mod with LONG_CYC=16, SHORT_CYC=4.
module tb_hw_mod;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       invk_hw = 1'b0;
    logic       car_on_fw = 1'b0;
    logic       invk_fw;
    logic [1:0] light_hw;
    logic       timer_hw_reset;

    int total = 0;
    int bad   = 0;

    // expected word: {light_hw, invk_fw, timer_hw_reset}
    logic [3:0] exp_q[$];

    hw_mod #(.LONG_CYC(16), .SHORT_CYC(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .invk_hw        (invk_hw),
        .car_on_fw      (car_on_fw),
        .invk_fw        (invk_fw),
        .light_hw       (light_hw),
        .timer_hw_reset (timer_hw_reset)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver: apply one cycle of inputs and queue the hand-derived response
    task automatic step(input logic rst, input logic car, input logic inv,
                        input logic [1:0] e_light, input logic e_fw, input logic e_trst);
        @(posedge clk);
        #1;
        reset     = rst;
        car_on_fw = car;
        invk_hw   = inv;
        exp_q.push_back({e_light, e_fw, e_trst});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            logic [3:0] a;
            e = exp_q.pop_front();
            a = {light_hw, invk_fw, timer_hw_reset};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle_check t=%0t light/fw/trst actual=%0d/%0b/%0b required=%0d/%0b/%0b",
                         $time, a[3:2], a[1], a[0], e[3:2], e[1], e[0]);
            end
        end
    end

    initial begin
        // power-up state equals reset state; timer reset asserted with reset
        step(1, 0, 0, G, 0, 1);
        step(1, 0, 0, G, 0, 1);

        // no car for 50 cycles: GREEN throughout, no grant
        for (int c = 0; c < 50; c++) step(0, 0, 0, G, 0, 0);

        // car from cycle 0 after reset
        step(1, 0, 0, G, 0, 1);
        for (int c = 0; c < 16; c++) step(0, 1, 0, G, 0, c == 15);
        for (int c = 16; c < 20; c++) step(0, 1, 0, Y, c == 19, c == 19);
        // RED holds with no timeout; RED cycle 10 brings invk_hw
        for (int c = 0; c < 10; c++) step(0, 1, 0, R, 0, 0);
        step(0, 1, 1, R, 0, 1);
        // car persists and invk_hw stays high through GREEN and YELLOW: ignored there
        for (int c = 0; c < 16; c++) step(0, 1, 1, G, 0, c == 15);
        for (int c = 0; c < 4; c++) step(0, 1, 1, Y, c == 3, c == 3);
        // first RED cycle with invk_hw still high returns to GREEN immediately
        step(0, 1, 1, R, 0, 1);
        step(0, 0, 0, G, 0, 0);

        // late car: arrives at cycle 30 after the counter saturated
        step(1, 0, 0, G, 0, 1);
        for (int c = 0; c < 30; c++) step(0, 0, c[0], G, 0, 0);
        step(0, 1, 0, G, 0, 1);
        // car drops during YELLOW: ignored
        step(0, 1, 0, Y, 0, 0);
        step(0, 0, 0, Y, 0, 0);
        step(0, 0, 0, Y, 0, 0);
        step(0, 1, 0, Y, 1, 1);
        for (int c = 35; c < 40; c++) step(0, c[0], 0, R, 0, 0);

        // reset mid-RED has priority
        step(1, 0, 1, R, 0, 1);
        for (int c = 0; c < 16; c++) step(0, 1, 0, G, 0, c == 15);
        step(0, 1, 0, Y, 0, 0);
        step(0, 1, 0, Y, 0, 0);
        // reset in the 3rd YELLOW cycle: grant never pulses
        step(1, 1, 0, Y, 0, 1);
        for (int c = 0; c < 20; c++) step(0, 0, 0, G, 0, 0);
        // counter restarted from 0 at the reset: a car yields after 16 GREEN cycles again
        step(1, 0, 0, G, 0, 1);
        for (int c = 0; c < 16; c++) step(0, 1, 0, G, 0, c == 15);
        step(0, 1, 0, Y, 0, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        if (total < 12) begin
            bad++;
            $display("FAIL check_count actual=%0d required>=12", total);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
